fir_tap_sequencer: RTL and testbench
====================================

Name: fir_tap_sequencer

Overview:
- Front end of the FIR datapath. Feeds the 64-cycle MAC one (sample, coefficient) pair per clock.
- Accepts input samples over a valid/ready handshake into a circular delay line, and holds a writable coefficient bank.
- Streams taps in lock-step with the MAC's free-running frame counter, so each MAC frame result is one filtered output sample.
- Also flags which MAC result pulses carry a real output.

Parameters:
- TAPS, 64, delay-line/coefficient depth and frame length; must be a power of two and equal to the MAC frame length (64).
- AW, 6, log2(TAPS); width of phase, head and coefficient address.
- DW, 16, sample and coefficient width (two's complement).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_valid  in  1  input sample valid
- s_data  in  DW  input sample
- s_ready  out  1  sequencer can accept a sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  AW  coefficient index k (multiplies k-th newest sample)
- coef_data  in  DW  coefficient value
- x  out  DW  sample to MAC x
- coeff  out  DW  coefficient to MAC coeff
- phase  out  AW  current tap index within frame
- frame_active  out  1  current frame carries a real sample
- y_valid  out  1  one-cycle pulse, coincident with MAC tick, when that tick's y is real
- overrun  out  1  sticky sample-loss flag (see Optional Feature)

Behaviour:
- Reset values:
  - phase=0, head=0, pending=0, frame_active=0, y_valid=0, overrun=0.
  - All TAPS delay-line entries = 0; all coefficients = 0.
  - s_ready=1 after reset.
- Frame alignment:
  - rst is shared with the MAC; phase increments every cycle and wraps TAPS-1 -> 0.
  - The cycle after rst deasserts is phase 0, matching the MAC's first accumulate.
- x and coeff are combinational from registered state (zero output latency):
  - coeff = coef[phase].
  - x = frame_active ? buf[(head+phase) mod TAPS] : 0.
  - The MAC samples them at the edge that ends the cycle.
- Input handshake:
  - Sample accepted at an edge with s_valid && s_ready; it is stored in a 1-deep pending register, pending <= 1.
  - s_ready = !pending.
- Wrap edge (phase == TAPS-1):
  - If pending: head <= head-1 (mod TAPS), buf[head-1] <= pending sample, pending <= 0, frame_active <= 1.
  - Else: frame_active <= 0; the frame streams x=0 and coefficients still cycle.
  - y_valid <= frame_active (value before update) for one cycle, so it coincides with the MAC tick for the frame just completed. At all other edges y_valid <= 0.
- Simultaneous s_valid at the wrap edge with pending=1: s_ready=0, so no accept. The next sample can be accepted from the following cycle.
- A sample accepted at the wrap edge with pending=0 is held until the next wrap. Latency from accept to its frame is 1..TAPS cycles.
- Throughput: max 1 sample per TAPS cycles.
- Coefficient writes are accepted at any time and take effect at the clock edge.
  - A read of the same address in the write cycle returns the old value.
  - Writes during a frame affect only taps not yet streamed.
- Delay-line index arithmetic is modulo TAPS via natural AW-bit wrap.
- rst mid-frame: all state returns to reset values next cycle, the pending sample is dropped, and phase restarts at 0 aligned with the MAC.

Optional Feature:
- Macro: FIR_SEQ_OVERRUN_EN.
- Defined:
  - s_ready is held 1.
  - A sample accepted while pending=1 overwrites the pending register and sets overrun=1 (sticky until rst).
  - At the wrap edge with an incoming sample, the old pending sample commits to the delay line and the new one becomes pending.
- Undefined: s_ready = !pending, and overrun is tied 0.

Test Plan:
- Reset release, no input for 130 cycles -> x=0 throughout; phase counts 0..63,0..; y_valid never asserts; s_ready=1.
- Write coef[0]=1, others 0; send sample 0x0100 at cycle 5 -> frame starting cycle 64 has x=0x0100 at phase 0; y_valid pulses at cycle 128 with the MAC tick; MAC y=0x00000100.
- Impulse 0x7FFF, then 64 zero samples, one per frame; coef[k]=k -> successive real outputs 0x7FFF*k for k=0..63, then 0.
- Hold s_valid=1 continuously -> exactly one accept per 64 cycles; s_ready low from accept until the wrap edge; no sample lost.
- Assert rst at phase 30 of an active frame with pending=1 -> next cycle phase=0, frame_active=0, s_ready=1, x=0, and all buffer entries read 0.
- FIR_SEQ_OVERRUN_EN defined: send samples A, B within one frame -> B streams next frame, A never appears, overrun=1 and stays 1 until rst.

Source files
------------

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer
//
// Front end of the FIR datapath. It presents one (sample, coefficient) pair
// per clock to a 64-cycle MAC that shares this block's reset, so the tap
// index here (phase) stays in lock-step with the MAC's frame counter.
// Input samples arrive over a valid/ready handshake. Each one is parked in a
// one-deep pending register and committed to a circular delay line at the
// next frame boundary. A writable coefficient bank supplies coeff.
//
// Optional feature macro: FIR_SEQ_OVERRUN_EN
//   undefined : s_ready = !pending, overrun tied 0
//   defined   : s_ready held 1. A sample accepted while one is already
//               pending replaces it and sets the sticky overrun flag.
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset (shared with the MAC)
//   s_valid      input sample valid
//   s_data       input sample (DW bits, two's complement)
//   s_ready      sequencer can accept a sample this cycle
//   coef_we      coefficient write strobe
//   coef_addr    coefficient index k (weights the k-th newest sample)
//   coef_data    coefficient value (DW bits, two's complement)
//   x            sample to the MAC (0 when the frame carries no real sample)
//   coeff        coefficient to the MAC
//   phase        tap index within the current frame
//   frame_active current frame carries a real sample
//   y_valid      one-cycle pulse with the MAC tick whose result is real
//   overrun      sticky sample-loss flag

module fir_tap_sequencer #(
  parameter int TAPS = 64,
  parameter int AW   = 6,
  parameter int DW   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [DW-1:0] coef_data,
  output logic [DW-1:0] x,
  output logic [DW-1:0] coeff,
  output logic [AW-1:0] phase,
  output logic          frame_active,
  output logic          y_valid,
  output logic          overrun
);

  logic [AW-1:0] head;
  logic          pending;
  logic [DW-1:0] pend_data;
  logic [DW-1:0] dline [TAPS];
  logic [DW-1:0] coef  [TAPS];

  logic          wrap;
  logic          accept;
  logic [AW-1:0] head_m1;
  logic [AW-1:0] rd_idx;

  // Last tap of the frame: the edge ending this cycle starts a new frame.
  assign wrap    = (phase == AW'(TAPS - 1));
  assign accept  = s_valid && s_ready;
  // The newest sample lives at head, so committing moves head back by one;
  // index arithmetic wraps naturally in AW bits.
  assign head_m1 = head - 1'b1;
  assign rd_idx  = head + phase;

  // Tap outputs are read straight from registered state so the MAC sees
  // the pair within the same cycle. Idle frames stream zero samples while
  // the coefficients keep cycling.
  assign x     = frame_active ? dline[rd_idx] : '0;
  assign coeff = coef[phase];

  // Frame counter, delay-line head, pending sample and frame flags.
  // A sample accepted on the wrap edge itself becomes pending for the next
  // frame. In overrun mode this edge also commits the previous pending
  // sample, so nothing is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase        <= '0;
      head         <= '0;
      pending      <= 1'b0;
      pend_data    <= '0;
      frame_active <= 1'b0;
      y_valid      <= 1'b0;
    end else begin
      phase   <= phase + 1'b1;
      y_valid <= wrap && frame_active;
      if (wrap) begin
        if (pending) begin
          head         <= head_m1;
          frame_active <= 1'b1;
        end else begin
          frame_active <= 1'b0;
        end
      end
      if (accept) begin
        pending   <= 1'b1;
        pend_data <= s_data;
      end else if (wrap) begin
        pending   <= 1'b0;
      end
    end
  end

  // Circular delay line. It is written only when a pending sample commits
  // at the frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) dline[i] <= '0;
    end else if (wrap && pending) begin
      dline[head_m1] <= pend_data;
    end
  end

  // Coefficient bank. A write lands at the edge, so a same-cycle read still
  // sees the old value and only taps not yet streamed pick up the change.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) coef[i] <= '0;
    end else if (coef_we) begin
      coef[coef_addr] <= coef_data;
    end
  end

`ifdef FIR_SEQ_OVERRUN_EN
  assign s_ready = 1'b1;

  // Overwriting a still-pending sample loses it. On the wrap edge the old
  // sample commits instead, so that edge never counts as a loss.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (accept && pending && !wrap) begin
      overrun <= 1'b1;
    end
  end
`else
  assign s_ready = !pending;
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb_fir_tap_sequencer
//
// Self-checking bench for fir_tap_sequencer. The reference model keeps the
// filter history as a queue of committed samples, newest first, and counts
// cycles since reset to find the frame position. Every cycle it predicts
// the tap outputs and handshake flags. It also accumulates the DUT's x*coeff
// pairs the way the MAC would and compares each real frame result with the
// convolution of the model's history and coefficients.

module tb_fir_tap_sequencer;

  localparam int TAPS = 64;

`ifdef FIR_SEQ_OVERRUN_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic        coef_we;
  logic [5:0]  coef_addr;
  logic [15:0] coef_data;
  logic [15:0] x;
  logic [15:0] coeff;
  logic [5:0]  phase;
  logic        frame_active;
  logic        y_valid;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  // Model state.
  bit          m_init = 1'b0;
  int          m_cnt;
  bit          m_pend;
  logic [15:0] m_pdata;
  bit          m_active;
  bit          m_yv;
  bit          m_ovr;
  bit          m_last_acc;
  logic [15:0] m_coef [TAPS];
  logic [15:0] m_hist [$];

  // MAC observer state.
  longint      obs_acc;
  longint      exp_y;
  bit          frame_dirty;
  bit          collect = 1'b0;
  longint      results [$];
  logic [15:0] obs_x;
  logic        obs_yv;

  fir_tap_sequencer #(.TAPS(TAPS), .AW(6), .DW(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .coef_data    (coef_data),
    .x            (x),
    .coeff        (coeff),
    .phase        (phase),
    .frame_active (frame_active),
    .y_valid      (y_valid),
    .overrun      (overrun)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit expReady();
    return OVR ? 1'b1 : !m_pend;
  endfunction

  function automatic longint prod(input logic [15:0] a, input logic [15:0] b);
    return longint'(signed'(a)) * longint'(signed'(b));
  endfunction

  // Predict the outputs of the current cycle and run the MAC observer.
  task automatic checkOutput();
    int ph;
    logic [15:0] exp_x;
    ph    = m_cnt % TAPS;
    exp_x = m_active ? m_hist[ph] : 16'h0000;
    obs_x  = x;
    obs_yv = y_valid;
    chk("phase",        {58'd0, phase},  64'(ph));
    chk("x",            {48'd0, x},      {48'd0, exp_x});
    chk("coeff",        {48'd0, coeff},  {48'd0, m_coef[ph]});
    chk("frame_active", {63'd0, frame_active}, {63'd0, m_active});
    chk("y_valid",      {63'd0, y_valid},      {63'd0, m_yv});
    chk("s_ready",      {63'd0, s_ready},      {63'd0, expReady()});
    chk("overrun",      {63'd0, overrun},      {63'd0, m_ovr});
    if (ph == 0) begin
      obs_acc     = 0;
      frame_dirty = 1'b0;
      exp_y       = 0;
      for (int k = 0; k < TAPS; k++) exp_y += prod(m_coef[k], m_hist[k]);
    end
    obs_acc += prod(x, coeff);
    if (ph == TAPS - 1 && m_active) begin
      if (!frame_dirty) chk("mac_y", obs_acc, exp_y);
      if (collect) results.push_back(obs_acc);
    end
  endtask

  // Advance the model by one clock edge with the inputs seen at that edge.
  task automatic modelEdge(input bit v, input logic [15:0] d, input bit we,
                           input logic [5:0] wa, input logic [15:0] wd, input bit r);
    bit wrap;
    bit acc;
    m_last_acc = 1'b0;
    if (r) begin
      m_init   = 1'b1;
      m_cnt    = 0;
      m_hist.delete();
      for (int i = 0; i < TAPS; i++) begin
        m_hist.push_back(16'h0000);
        m_coef[i] = 16'h0000;
      end
      m_pend   = 1'b0;
      m_pdata  = 16'h0000;
      m_active = 1'b0;
      m_yv     = 1'b0;
      m_ovr    = 1'b0;
      return;
    end
    if (!m_init) return;
    wrap = (m_cnt % TAPS) == TAPS - 1;
    acc  = v && expReady();
`ifdef FIR_SEQ_OVERRUN_EN
    if (acc && m_pend && !wrap) m_ovr = 1'b1;
`endif
    m_yv = wrap && m_active;
    if (wrap) begin
      if (m_pend) begin
        m_hist.push_front(m_pdata);
        void'(m_hist.pop_back());
        m_active = 1'b1;
        m_pend   = 1'b0;
      end else begin
        m_active = 1'b0;
      end
    end
    if (acc) begin
      m_pend     = 1'b1;
      m_pdata    = d;
      m_last_acc = 1'b1;
    end
    if (we) begin
      m_coef[wa]  = wd;
      frame_dirty = 1'b1;
    end
    m_cnt++;
  endtask

  // One clock cycle: drive, check, let the edge happen, update the model.
  task automatic applyStimulus(input bit v, input logic [15:0] d, input bit we,
                               input logic [5:0] wa, input logic [15:0] wd, input bit r);
    s_valid   = v;
    s_data    = d;
    coef_we   = we;
    coef_addr = wa;
    coef_data = wd;
    rst       = r;
    #1;
    if (m_init) checkOutput();
    @(posedge clk);
    modelEdge(v, d, we, wa, wd, r);
    @(negedge clk);
  endtask

  initial begin
    bit imp_sent;
    s_valid = 1'b0; s_data = '0; coef_we = 1'b0; coef_addr = '0; coef_data = '0; rst = 1'b1;
    @(negedge clk);

    // Reset release, then idle: phase counts, x stays 0, no y_valid.
    repeat (2) applyStimulus(1'b0, 16'h0, 1'b0, 6'd0, 16'h0, 1'b1);
    for (int i = 0; i < 130; i++) applyStimulus(1'b0, 16'h0, 1'b0, 6'd0, 16'h0, 1'b0);

    // coef[0]=1, sample 0x0100 at cycle 5: real frame at 64, y pulse at 128.
    applyStimulus(1'b0, 16'h0, 1'b0, 6'd0, 16'h0, 1'b1);
    for (int i = 0; i < 200; i++) begin
      applyStimulus(i == 5, 16'h0100, i == 0, 6'd0, 16'h0001, 1'b0);
      if (i == 64)  chk("dir_x_cycle64", {48'd0, obs_x}, 64'h0100);
      if (i == 127) chk("dir_y_frame", obs_acc, 64'h100);
      if (i == 128) chk("dir_yvalid_cycle128", {63'd0, obs_yv}, 64'd1);
    end

    // Reset at phase 30 of an active frame with a sample pending, then a
    // fresh sample to show the delay line came back as zeros.
    applyStimulus(1'b0, 16'h0, 1'b0, 6'd0, 16'h0, 1'b1);
    for (int i = 0; i < TAPS + 30; i++)
      applyStimulus(i == 0 || i == TAPS + 2, (i == 0) ? 16'h1234 : 16'h0055,
                    i < TAPS, 6'(i), 16'(i + 1), 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b0, 6'd0, 16'h0, 1'b1);
    for (int i = 0; i < 3 * TAPS; i++)
      applyStimulus(i == 2, 16'h0ABC, i >= 3 && i < 3 + TAPS, 6'(i - 3), 16'h0101, 1'b0);

`ifdef FIR_SEQ_OVERRUN_EN
    // Two samples in one frame: B replaces A, overrun sticks until reset.
    applyStimulus(1'b0, 16'h0, 1'b0, 6'd0, 16'h0, 1'b1);
    for (int i = 0; i < 3 * TAPS; i++)
      applyStimulus(i == 3 || i == 10, (i == 3) ? 16'h1111 : 16'h2222, i == 0, 6'd0, 16'h0001, 1'b0);
    chk("ovr_sticky", {63'd0, overrun}, 64'd1);
`endif

    // Randomised traffic with occasional coefficient writes and resets.
    for (int i = 0; i < 1500; i++)
      applyStimulus($urandom_range(0, 3) == 0, 16'($urandom), $urandom_range(0, 7) == 0,
                    6'($urandom), 16'($urandom), $urandom_range(0, 499) == 0);

    // Impulse response: coef[k]=k, one 0x7FFF sample then zeros with
    // valid held high; outputs must read 0x7FFF*k then 0.
    applyStimulus(1'b0, 16'h0, 1'b0, 6'd0, 16'h0, 1'b1);
    for (int i = 0; i < TAPS; i++) applyStimulus(1'b0, 16'h0, 1'b1, 6'(i), 16'(i), 1'b0);
    imp_sent = 1'b0;
    collect  = 1'b1;
    results.delete();
    for (int i = 0; i < TAPS * 70 && results.size() < TAPS + 1; i++) begin
      applyStimulus(OVR ? !m_pend : 1'b1, imp_sent ? 16'h0000 : 16'h7FFF, 1'b0, 6'd0, 16'h0, 1'b0);
      if (m_last_acc) imp_sent = 1'b1;
    end
    collect = 1'b0;
    chk("imp_count", 64'(results.size()), 64'(TAPS + 1));
    for (int j = 0; j < TAPS + 1 && j < results.size(); j++)
      chk("imp_y", results[j], (j < TAPS) ? longint'(32767 * j) : 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
